// File: rtl/histogram_engine.sv
// Streaming pixel histogram: reads packed pixel words, accumulates saturating bin
// counters in an external scratch RAM through a read/modify/write pipeline with forwarding.
module histogram_engine #(
    parameter int PIX_W     = 8,
    parameter int BIN_SHIFT = 2,
    parameter int MEM_W     = 128,
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 16,
    parameter int NUM_PIX   = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_clear,
    input  logic [ADDR_W-1:0] i_in_base,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sat_flag,
    output logic              o_in_rd_en,
    output logic [ADDR_W-1:0] o_in_addr,
    input  logic [MEM_W-1:0]  i_in_rdata,
    output logic              o_scr_rd_en,
    output logic [ADDR_W-1:0] o_scr_raddr,
    input  logic [MEM_W-1:0]  i_scr_rdata,
    output logic              o_scr_we,
    output logic [ADDR_W-1:0] o_scr_waddr,
    output logic [MEM_W-1:0]  o_scr_wdata
);

    localparam int BIN_W     = PIX_W - BIN_SHIFT;
    localparam int NUM_BINS  = 1 << BIN_W;
    localparam int PPW       = MEM_W / PIX_W;
    localparam int BPW       = MEM_W / CNT_W;
    localparam int SW        = NUM_BINS / BPW;
    localparam int NUM_WORDS = NUM_PIX / PPW;
    localparam int PIX_IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int LANE_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int LANE_SH   = $clog2(BPW);

    localparam logic [ADDR_W-1:0]    SW_LAST    = ADDR_W'(SW - 1);
    localparam logic [ADDR_W-1:0]    WORDS_LAST = ADDR_W'(NUM_WORDS - 1);
    localparam logic [PIX_IDX_W-1:0] PIX_LAST   = PIX_IDX_W'(PPW - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_WAIT, S_PROC, S_DRAIN, S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;

    logic [ADDR_W-1:0]     r_base;
    logic [ADDR_W-1:0]     r_word_idx;
    logic [ADDR_W-1:0]     r_clr_cnt;
    logic [PIX_IDX_W-1:0]  r_pix_idx;
    logic                  r_drain_cnt;
    logic [MEM_W-1:0]      r_word;
    logic                  r_sat;

    logic                  r_s1_valid;
    logic [ADDR_W-1:0]     r_s1_word;
    logic [LANE_W-1:0]     r_s1_lane;

    logic                  r_scr_we;
    logic [ADDR_W-1:0]     r_scr_waddr;
    logic [MEM_W-1:0]      r_scr_wdata;
    logic                  r_fwd2_valid;
    logic [ADDR_W-1:0]     r_fwd2_addr;
    logic [MEM_W-1:0]      r_fwd2_data;

    logic [PIX_W-1:0]      w_pix_arr [PPW];
    logic [PIX_W-1:0]      w_pix;
    logic [BIN_W-1:0]      w_bin;
    logic [ADDR_W-1:0]     w_word_sel;
    logic [LANE_W-1:0]     w_lane_sel;

    logic [MEM_W-1:0]      w_src;
    logic [CNT_W-1:0]      w_src_lane [BPW];
    logic [CNT_W-1:0]      w_old_lane;
    logic                  w_lane_sat;
    logic                  w_sat;
    logic [MEM_W-1:0]      w_merged;

    genvar gi;

    // Pixel k sits at bits [k*PIX_W +: PIX_W] of the latched input word.
    generate
        for (gi = 0; gi < PPW; gi++) begin : g_pix
            assign w_pix_arr[gi] = r_word[gi*PIX_W +: PIX_W];
        end
    endgenerate

    assign w_pix      = w_pix_arr[r_pix_idx];
    assign w_bin      = BIN_W'(w_pix >> BIN_SHIFT);
    assign w_word_sel = ADDR_W'(w_bin >> LANE_SH);
    assign w_lane_sel = LANE_W'(w_bin & BIN_W'(BPW - 1));

    // The two most recent writes have not reached the RAM read data yet, newest wins.
    assign w_src = (r_scr_we && (r_scr_waddr == r_s1_word))        ? r_scr_wdata :
                   (r_fwd2_valid && (r_fwd2_addr == r_s1_word))    ? r_fwd2_data :
                                                                     i_scr_rdata;

    generate
        for (gi = 0; gi < BPW; gi++) begin : g_lane
            assign w_src_lane[gi] = w_src[gi*CNT_W +: CNT_W];
            assign w_merged[gi*CNT_W +: CNT_W] =
                ((r_s1_lane == LANE_W'(gi)) && !w_lane_sat) ? w_src_lane[gi] + CNT_W'(1)
                                                             : w_src_lane[gi];
        end
    endgenerate

    assign w_old_lane = w_src_lane[r_s1_lane];
    assign w_lane_sat = &w_old_lane;
    assign w_sat      = r_s1_valid && w_lane_sat;
    assign w_accept   = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_in_rd_en   = 1'b0;
        o_in_addr    = '0;
        o_scr_rd_en  = 1'b0;
        o_scr_raddr  = '0;
        o_busy       = 1'b1;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_next = i_clear ? S_CLEAR : S_FETCH;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == SW_LAST) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                o_in_rd_en   = 1'b1;
                o_in_addr    = r_base + r_word_idx;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_state_next = S_PROC;
            end
            S_PROC: begin
                o_scr_rd_en = 1'b1;
                o_scr_raddr = w_word_sel;
                if (r_pix_idx == PIX_LAST) begin
                    w_state_next = (r_word_idx == WORDS_LAST) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_busy       = 1'b0;
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base       <= '0;
            r_word_idx   <= '0;
            r_clr_cnt    <= '0;
            r_pix_idx    <= '0;
            r_drain_cnt  <= 1'b0;
            r_word       <= '0;
            r_sat        <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_word    <= '0;
            r_s1_lane    <= '0;
            r_scr_we     <= 1'b0;
            r_scr_waddr  <= '0;
            r_scr_wdata  <= '0;
            r_fwd2_valid <= 1'b0;
            r_fwd2_addr  <= '0;
            r_fwd2_data  <= '0;
        end else begin
            if (w_accept) begin
                r_base      <= i_in_base;
                r_word_idx  <= '0;
                r_clr_cnt   <= '0;
                r_pix_idx   <= '0;
                r_drain_cnt <= 1'b0;
                r_sat       <= 1'b0;
            end
            if (r_state == S_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            end
            if (r_state == S_WAIT) begin
                r_word    <= i_in_rdata;
                r_pix_idx <= '0;
            end
            if (r_state == S_PROC) begin
                r_pix_idx <= r_pix_idx + PIX_IDX_W'(1);
                if (r_pix_idx == PIX_LAST) begin
                    r_word_idx <= r_word_idx + ADDR_W'(1);
                end
            end
            if (r_state == S_DRAIN) begin
                r_drain_cnt <= ~r_drain_cnt;
            end

            r_s1_valid <= (r_state == S_PROC);
            r_s1_word  <= w_word_sel;
            r_s1_lane  <= w_lane_sel;

            if (r_state == S_CLEAR) begin
                r_scr_we    <= 1'b1;
                r_scr_waddr <= r_clr_cnt;
                r_scr_wdata <= '0;
            end else if (r_s1_valid) begin
                r_scr_we    <= 1'b1;
                r_scr_waddr <= r_s1_word;
                r_scr_wdata <= w_merged;
                if (w_sat) begin
                    r_sat <= 1'b1;
                end
            end else begin
                r_scr_we <= 1'b0;
            end

            r_fwd2_valid <= r_scr_we;
            r_fwd2_addr  <= r_scr_waddr;
            r_fwd2_data  <= r_scr_wdata;
        end
    end

    assign o_sat_flag  = r_sat;
    assign o_scr_we    = r_scr_we;
    assign o_scr_waddr = r_scr_waddr;
    assign o_scr_wdata = r_scr_wdata;

endmodule

// File: tb/tb_histogram_engine.sv
// Directed bench for histogram_engine with a 16-pixel frame: behavioural RAMs,
// a write-port monitor and a simple sequential histogram model.
module tb_histogram_engine;

    localparam int MW = 128;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] in_base = '0;
    logic          busy, done, sat_flag;
    logic          in_rd_en, scr_rd_en, scr_we;
    logic [AW-1:0] in_addr, scr_raddr, scr_waddr;
    logic [MW-1:0] in_rdata, scr_rdata, scr_wdata;

    logic [MW-1:0] in_mem  [0:15];
    logic [MW-1:0] scr_mem [0:15];
    logic          pre_we = 1'b0;
    logic [3:0]    pre_addr = '0;
    logic [MW-1:0] pre_data = '0;

    int            n_chk = 0;
    int            n_pass = 0;
    int            n_fail = 0;

    int            wcnt = 0;
    int            wbase = 0;
    logic [AW-1:0] wlog_a [0:511];
    logic [MW-1:0] wlog_d [0:511];
    logic [AW-1:0] last_in_addr = '0;

    logic [MW-1:0] model [0:15];
    logic [AW-1:0] exp_a [0:63];
    logic [MW-1:0] exp_d [0:63];
    int            exp_n;
    bit            exp_sat;

    histogram_engine #(.NUM_PIX(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_clear     (clear),
        .i_in_base   (in_base),
        .o_busy      (busy),
        .o_done      (done),
        .o_sat_flag  (sat_flag),
        .o_in_rd_en  (in_rd_en),
        .o_in_addr   (in_addr),
        .i_in_rdata  (in_rdata),
        .o_scr_rd_en (scr_rd_en),
        .o_scr_raddr (scr_raddr),
        .i_scr_rdata (scr_rdata),
        .o_scr_we    (scr_we),
        .o_scr_waddr (scr_waddr),
        .o_scr_wdata (scr_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_rd_en) in_rdata <= in_mem[in_addr[3:0]];
    end

    // Read-before-write scratch RAM; preload port used only while the engine is idle.
    always @(posedge clk) begin
        if (scr_rd_en) scr_rdata <= scr_mem[scr_raddr[3:0]];
        if (scr_we) scr_mem[scr_waddr[3:0]] <= scr_wdata;
        else if (pre_we) scr_mem[pre_addr] <= pre_data;
    end

    always @(negedge clk) begin
        if (scr_we === 1'b1) begin
            wlog_a[wcnt % 512] = scr_waddr;
            wlog_d[wcnt % 512] = scr_wdata;
            wcnt++;
        end
        if (in_rd_en === 1'b1) last_in_addr = in_addr;
    end

    task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sequential reference: one pixel at a time, saturating counters, no pipeline.
    task automatic model_frame(input logic [MW-1:0] word, input bit clr);
        logic [7:0]  pix;
        logic [31:0] lane;
        int          bin, w, l;
        exp_n   = 0;
        exp_sat = 0;
        if (clr) begin
            for (int i = 0; i < 16; i++) begin
                model[i]     = '0;
                exp_a[exp_n] = AW'(i);
                exp_d[exp_n] = '0;
                exp_n++;
            end
        end
        for (int k = 0; k < 16; k++) begin
            pix  = word[k*8 +: 8];
            bin  = int'(pix) >> 2;
            w    = bin / 4;
            l    = bin % 4;
            lane = model[w][l*32 +: 32];
            if (lane == 32'hFFFF_FFFF) exp_sat = 1;
            else model[w][l*32 +: 32] = lane + 32'd1;
            exp_a[exp_n] = AW'(w);
            exp_d[exp_n] = model[w];
            exp_n++;
        end
    endtask

    task automatic run_frame(input logic [AW-1:0] base, input bit clr, input int restart_at,
                             output int dcyc);
        int cyc;
        @(negedge clk);
        in_base = base;
        clear   = clr;
        start   = 1'b1;
        wbase   = wcnt;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        cyc   = 1;
        chk("busy_after_start", MW'(busy), MW'(1));
        chk("sat_cleared_by_start", MW'(sat_flag), MW'(0));
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == restart_at) begin
                start   = 1'b1;
                in_base = 16'h0005;
                clear   = 1'b0;
            end else begin
                start = 1'b0;
            end
        end
        dcyc = cyc;
        chk("busy_low_with_done", MW'(busy), MW'(0));
        @(negedge clk);
        chk("done_one_cycle", MW'(done), MW'(0));
    endtask

    task automatic check_frame(input string name);
        chk({name, "_write_count"}, MW'(wcnt - wbase), MW'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            chk($sformatf("%s_waddr%0d", name, i), MW'(wlog_a[(wbase + i) % 512]), MW'(exp_a[i]));
            chk($sformatf("%s_wdata%0d", name, i), wlog_d[(wbase + i) % 512], exp_d[i]);
        end
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_final_word%0d", name, i), scr_mem[i], model[i]);
        end
        chk({name, "_sat_flag"}, MW'(sat_flag), MW'(exp_sat));
    endtask

    initial begin
        int            d;
        int            n;
        logic [MW-1:0] tmp;

        #1;
        chk("rst_busy", MW'(busy), MW'(0));
        chk("rst_done", MW'(done), MW'(0));
        chk("rst_sat", MW'(sat_flag), MW'(0));
        chk("rst_scr_we", MW'(scr_we), MW'(0));
        chk("rst_scr_rd_en", MW'(scr_rd_en), MW'(0));
        chk("rst_in_rd_en", MW'(in_rd_en), MW'(0));
        chk("rst_in_addr", MW'(in_addr), MW'(0));
        chk("rst_scr_waddr", MW'(scr_waddr), MW'(0));
        chk("rst_scr_wdata", scr_wdata, MW'(0));

        in_mem[0] = '0;
        in_mem[4] = '0;
        in_mem[5] = '0;
        for (int k = 0; k < 16; k++) tmp[k*8 +: 8] = 8'(k * 4);
        in_mem[1] = tmp;
        tmp = {16{8'h40}};
        tmp[7:0] = 8'h00; tmp[15:8] = 8'h10; tmp[23:16] = 8'h00; tmp[31:24] = 8'h10; tmp[39:32] = 8'h00;
        in_mem[2] = tmp;
        tmp = {16{8'hFC}};
        tmp[7:0] = 8'h00;
        in_mem[3] = tmp;
        for (int i = 6; i < 16; i++) in_mem[i] = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_release_we", MW'(scr_we), MW'(0));
        chk("idle_after_release_busy", MW'(busy), MW'(0));

        // All-zero pixels with clear: 16 zero writes, then lane0 counts 1..16 in word 0.
        model_frame(in_mem[5], 1'b1);
        run_frame(16'h0005, 1'b1, 0, d);
        $display("frame zeros: done at cycle %0d, writes %0d", d, wcnt - wbase);
        chk("zeros_done_cycle", MW'(d), MW'(37));
        check_frame("zeros");
        chk("zeros_word0", scr_mem[0], 128'h0000_0000_0000_0000_0000_0000_0000_0010);
        chk("zeros_in_addr", MW'(last_in_addr), MW'(5));

        // One pixel per bin 0..15: words 0..3 end with every lane at 1.
        model_frame(in_mem[1], 1'b1);
        run_frame(16'h0001, 1'b1, 0, d);
        $display("frame ramp: done at cycle %0d, writes %0d", d, wcnt - wbase);
        chk("ramp_done_cycle", MW'(d), MW'(37));
        check_frame("ramp");
        chk("ramp_word0", scr_mem[0], 128'h0000_0001_0000_0001_0000_0001_0000_0001);
        chk("ramp_word3", scr_mem[3], 128'h0000_0001_0000_0001_0000_0001_0000_0001);
        chk("ramp_word4", scr_mem[4], MW'(0));

        // A,B,A,B,A alternation exercises the two-back forwarding path.
        model_frame(in_mem[2], 1'b1);
        run_frame(16'h0002, 1'b1, 0, d);
        $display("frame hazard: done at cycle %0d, writes %0d", d, wcnt - wbase);
        chk("hazard_done_cycle", MW'(d), MW'(37));
        check_frame("hazard");
        chk("hazard_word0", scr_mem[0], MW'(3));
        chk("hazard_word1", scr_mem[1], MW'(2));
        chk("hazard_word4", scr_mem[4], MW'(11));

        // Saturation: word0 lane0 preloaded full, lane1 must pass through untouched.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            pre_addr = 4'(i);
            pre_data = (i == 0) ? 128'h0000_0000_0000_0000_0000_0007_FFFF_FFFF : '0;
            pre_we   = 1'b1;
            model[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        model_frame(in_mem[3], 1'b0);
        run_frame(16'h0003, 1'b0, 0, d);
        $display("frame saturate: done at cycle %0d, writes %0d", d, wcnt - wbase);
        chk("sat_done_cycle", MW'(d), MW'(21));
        check_frame("sat");
        chk("sat_word0", scr_mem[0], 128'h0000_0000_0000_0000_0000_0007_FFFF_FFFF);
        chk("sat_word15", scr_mem[15], 128'h0000_000F_0000_0000_0000_0000_0000_0000);
        repeat (3) @(negedge clk);
        chk("sat_sticky", MW'(sat_flag), MW'(1));

        // Second start mid-frame with another base and clear=0 must be ignored.
        model_frame(in_mem[1], 1'b1);
        run_frame(16'h0001, 1'b1, 25, d);
        $display("frame restart-ignored: done at cycle %0d, writes %0d", d, wcnt - wbase);
        chk("restart_done_cycle", MW'(d), MW'(37));
        check_frame("restart");
        chk("restart_in_addr", MW'(last_in_addr), MW'(1));

        // Asynchronous reset while a write is on the port.
        @(negedge clk);
        in_base = 16'h0005;
        clear   = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        n = 0;
        while (scr_we !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midframe_write_seen", MW'(scr_we), MW'(1));
        #1 rst_n = 1'b0;
        #1;
        $display("async reset asserted mid-write at %0t", $time);
        chk("async_rst_we", MW'(scr_we), MW'(0));
        chk("async_rst_busy", MW'(busy), MW'(0));
        chk("async_rst_waddr", MW'(scr_waddr), MW'(0));
        chk("async_rst_wdata", scr_wdata, MW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst_we%0d", i), MW'(scr_we), MW'(0));
            chk($sformatf("post_rst_busy%0d", i), MW'(busy), MW'(0));
            chk($sformatf("post_rst_in_rd%0d", i), MW'(in_rd_en), MW'(0));
            chk($sformatf("post_rst_scr_rd%0d", i), MW'(scr_rd_en), MW'(0));
        end

        // Frame after the abandoned one behaves as after power-up.
        model_frame(in_mem[5], 1'b1);
        run_frame(16'h0005, 1'b1, 0, d);
        $display("frame after reset: done at cycle %0d, writes %0d", d, wcnt - wbase);
        chk("after_rst_done_cycle", MW'(d), MW'(37));
        check_frame("after_rst");
        chk("after_rst_word0", scr_mem[0], 128'h0000_0000_0000_0000_0000_0000_0000_0010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
